// File: rtl/frontend_pkg.sv
// Shared frontend types and constants for the aligner -> buffer -> decode path.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package frontend_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 64;

    localparam logic [PC_W-1:0] INSTR_STEP = 64'd4;

    // Fetch-group valid masks; 2'b10 is never produced by a legal aligner.
    localparam logic [1:0] ENQ_NONE = 2'b00;
    localparam logic [1:0] ENQ_ONE  = 2'b01;
    localparam logic [1:0] ENQ_TWO  = 2'b11;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } ibuf_entry_t;

    // Number of buffer slots a mask claims; the illegal mask claims none.
    function automatic logic [1:0] mask_slots(input logic [1:0] mask);
        case (mask)
            ENQ_ONE: return 2'd1;
            ENQ_TWO: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/ibuf_mem.sv
// Instruction buffer storage: DEPTH entries, two write ports, one async read port.
// Latency: writes land at the clock edge; read data is combinational from raddr.
// Backpressure: none here; the owner guarantees write addresses are free slots.
module ibuf_mem
    import frontend_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we0,
    input  logic [PTR_W-1:0] waddr0,
    input  ibuf_entry_t      wdata0,
    input  logic             we1,
    input  logic [PTR_W-1:0] waddr1,
    input  ibuf_entry_t      wdata1,
    input  logic [PTR_W-1:0] raddr,
    output ibuf_entry_t      rdata
);

    ibuf_entry_t mem [DEPTH];

    // Both ports may write in one cycle; the controller always gives them distinct slots.
    always_ff @(posedge clock) begin
        if (we0) mem[waddr0] <= wdata0;
        if (we1) mem[waddr1] <= wdata1;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_buffer.sv
// Frontend instruction queue: accepts 0/1/2 instrs per cycle, issues 1 per cycle to decode.
// Latency: an instruction written in cycle N is visible at deq in cycle N+1 (no bypass).
// Backpressure: enq_ready drops when fewer than 2 slots are free; flush drops everything.
module instr_buffer
    import frontend_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [2*INSTR_W-1:0] enq_instr,
    input  logic [1:0]           enq_valid,
    input  logic [PC_W-1:0]      enq_pc,
    output logic                 enq_ready,
    output logic                 deq_valid,
    input  logic                 deq_ready,
    output logic [INSTR_W-1:0]   deq_instr,
    output logic [PC_W-1:0]      deq_pc,
    output logic [PTR_W:0]       count
);

    // Ready means at least two free slots, so a 2-wide group always fits whole.
    localparam logic [PTR_W:0] READY_MAX = (PTR_W+1)'(DEPTH - 2);
    localparam logic [PTR_W:0] PTR_ONE   = (PTR_W+1)'(1);

    logic [PTR_W:0] wptr;
    logic [PTR_W:0] rptr;
    logic [PTR_W:0] wptr_p1;
    logic [PTR_W:0] enq_add;
    logic [PTR_W:0] deq_sub;
    logic [1:0]     n_enq;
    logic           not_empty;
    logic           deq_fire;
    ibuf_entry_t    wr_entry0;
    ibuf_entry_t    wr_entry1;
    ibuf_entry_t    rd_entry;

    assign not_empty = (count != '0);
    assign enq_ready = (count <= READY_MAX);
    assign n_enq     = (enq_ready && !flush) ? mask_slots(enq_valid) : 2'd0;
    assign deq_valid = not_empty && !flush;
    assign deq_fire  = deq_valid && deq_ready;

    assign enq_add = {{(PTR_W-1){1'b0}}, n_enq};
    assign deq_sub = {{PTR_W{1'b0}}, deq_fire};
    assign wptr_p1 = wptr + PTR_ONE;

    assign wr_entry0 = '{instr: enq_instr[INSTR_W-1:0],         pc: enq_pc};
    assign wr_entry1 = '{instr: enq_instr[2*INSTR_W-1:INSTR_W], pc: enq_pc + INSTR_STEP};

    ibuf_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clock  (clock),
        .we0    (n_enq != 2'd0),
        .waddr0 (wptr[PTR_W-1:0]),
        .wdata0 (wr_entry0),
        .we1    (n_enq == 2'd2),
        .waddr1 (wptr_p1[PTR_W-1:0]),
        .wdata1 (wr_entry1),
        .raddr  (rptr[PTR_W-1:0]),
        .rdata  (rd_entry)
    );

    // Stale storage is hidden so an empty buffer presents zeros to decode.
    assign deq_instr = not_empty ? rd_entry.instr : '0;
    assign deq_pc    = not_empty ? rd_entry.pc    : '0;

    // Pointer and occupancy update; a redirect flush overrides any same-cycle enq/deq.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + enq_add;
            rptr  <= rptr + deq_sub;
            count <= count + enq_add - deq_sub;
        end
    end

    // The aligner never emits a lone upper instruction; such a mask is dropped above.
    assert property (@(posedge clock) disable iff (reset) enq_valid != 2'b10);

endmodule

// File: tb/tb_instr_buffer.sv
module tb_instr_buffer;
    import frontend_pkg::*;

    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic [63:0] enq_instr;
    logic [1:0]  enq_valid;
    logic [63:0] enq_pc;
    logic        enq_ready;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_instr;
    logic [63:0] deq_pc;
    logic [3:0]  count;

    int errors = 0;
    int checks = 0;

    instr_buffer #(.DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .enq_instr (enq_instr),
        .enq_valid (enq_valid),
        .enq_pc    (enq_pc),
        .enq_ready (enq_ready),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .deq_instr (deq_instr),
        .deq_pc    (deq_pc),
        .count     (count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  v;
        logic [63:0] instr;
        logic [63:0] pc;
        logic        dr;
        logic [3:0]  e_count;
        logic        e_dv;
        logic [31:0] e_instr;
        logic [63:0] e_pc;
        logic        e_rdy;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } ent_t;

    vec_t vecs [17];
    ent_t q [$];

    function automatic vec_t mkv(input logic [1:0] v, input logic [63:0] instr,
                                 input logic [63:0] pc, input logic dr,
                                 input logic [3:0] e_count, input logic e_dv,
                                 input logic [31:0] e_instr, input logic [63:0] e_pc,
                                 input logic e_rdy);
        vec_t r;
        r.v = v; r.instr = instr; r.pc = pc; r.dr = dr;
        r.e_count = e_count; r.e_dv = e_dv; r.e_instr = e_instr; r.e_pc = e_pc; r.e_rdy = e_rdy;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic f, input logic [1:0] v, input logic [63:0] i,
                         input logic [63:0] p, input logic dr);
        flush = f; enq_valid = v; enq_instr = i; enq_pc = p; deq_ready = dr;
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 64'd0, 64'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] e_count, input logic e_dv,
                           input logic [31:0] e_instr, input logic [63:0] e_pc, input logic e_rdy);
        chk({tag, ".count"},     64'(count),     64'(e_count));
        chk({tag, ".deq_valid"}, 64'(deq_valid), 64'(e_dv));
        chk({tag, ".deq_instr"}, 64'(deq_instr), 64'(e_instr));
        chk({tag, ".deq_pc"},    deq_pc,         e_pc);
        chk({tag, ".enq_ready"}, 64'(enq_ready), 64'(e_rdy));
    endtask

    initial begin
        logic [1:0]  hv;
        logic [63:0] hi;
        logic [63:0] hp;
        logic        f;
        logic        dr;
        logic        exp_rdy;
        logic        exp_dv;
        bit          holding;

        // Two-wide push then pops, followed by the fill-to-seven backpressure case.
        vecs[0]  = mkv(2'b11, 64'hBBBB_BBBB_AAAA_AAAA, 64'h8000_0000, 1'b0, 4'd2, 1'b1, 32'hAAAA_AAAA, 64'h8000_0000, 1'b1);
        vecs[1]  = mkv(2'b00, 64'd0, 64'd0, 1'b1, 4'd1, 1'b1, 32'hBBBB_BBBB, 64'h8000_0004, 1'b1);
        vecs[2]  = mkv(2'b00, 64'd0, 64'd0, 1'b1, 4'd0, 1'b0, 32'h0, 64'h0, 1'b1);
        vecs[3]  = mkv(2'b11, 64'h2222_2222_1111_1111, 64'h1000, 1'b0, 4'd2, 1'b1, 32'h1111_1111, 64'h1000, 1'b1);
        vecs[4]  = mkv(2'b11, 64'h4444_4444_3333_3333, 64'h2000, 1'b0, 4'd4, 1'b1, 32'h1111_1111, 64'h1000, 1'b1);
        vecs[5]  = mkv(2'b11, 64'h6666_6666_5555_5555, 64'h3000, 1'b0, 4'd6, 1'b1, 32'h1111_1111, 64'h1000, 1'b1);
        vecs[6]  = mkv(2'b01, 64'hDEAD_BEEF_7777_7777, 64'h4000, 1'b0, 4'd7, 1'b1, 32'h1111_1111, 64'h1000, 1'b0);
        vecs[7]  = mkv(2'b01, 64'h0000_0000_8888_8888, 64'h5000, 1'b0, 4'd7, 1'b1, 32'h1111_1111, 64'h1000, 1'b0);
        vecs[8]  = mkv(2'b01, 64'h0000_0000_8888_8888, 64'h5000, 1'b1, 4'd6, 1'b1, 32'h2222_2222, 64'h1004, 1'b1);
        vecs[9]  = mkv(2'b01, 64'h0000_0000_8888_8888, 64'h5000, 1'b0, 4'd7, 1'b1, 32'h2222_2222, 64'h1004, 1'b0);
        vecs[10] = mkv(2'b00, 64'd0, 64'd0, 1'b1, 4'd6, 1'b1, 32'h3333_3333, 64'h2000, 1'b1);
        vecs[11] = mkv(2'b00, 64'd0, 64'd0, 1'b1, 4'd5, 1'b1, 32'h4444_4444, 64'h2004, 1'b1);
        vecs[12] = mkv(2'b00, 64'd0, 64'd0, 1'b1, 4'd4, 1'b1, 32'h5555_5555, 64'h3000, 1'b1);
        vecs[13] = mkv(2'b00, 64'd0, 64'd0, 1'b1, 4'd3, 1'b1, 32'h6666_6666, 64'h3004, 1'b1);
        vecs[14] = mkv(2'b00, 64'd0, 64'd0, 1'b1, 4'd2, 1'b1, 32'h7777_7777, 64'h4000, 1'b1);
        vecs[15] = mkv(2'b00, 64'd0, 64'd0, 1'b1, 4'd1, 1'b1, 32'h8888_8888, 64'h5000, 1'b1);
        vecs[16] = mkv(2'b00, 64'd0, 64'd0, 1'b1, 4'd0, 1'b0, 32'h0, 64'h0, 1'b1);

        idle();
        reset = 1'b1;
        #12;
        reset = 1'b0;
        #1;
        chk_out("reset", 4'd0, 1'b0, 32'h0, 64'h0, 1'b1);

        for (int i = 0; i < 17; i++) begin
            drive(1'b0, vecs[i].v, vecs[i].instr, vecs[i].pc, vecs[i].dr);
            tick();
            idle();
            #1;
            chk_out($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_dv,
                    vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_rdy);
        end

        // Wrap: cycle seven singles through so both pointers sit at slot 7, then push two.
        reset = 1'b1;
        #2;
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 2'b01, {32'h0, 32'hE000_0000 + 32'(i)}, 64'(i * 16), 1'b1);
            #1;
            if (i > 0) chk($sformatf("wrap_pre%0d.instr", i), 64'(deq_instr), 64'(32'hE000_0000 + 32'(i - 1)));
            tick();
        end
        drive(1'b0, 2'b00, 64'd0, 64'd0, 1'b1);
        tick();
        idle();
        #1;
        chk("wrap_pre.count", 64'(count), 64'd0);
        drive(1'b0, 2'b11, 64'hCCCC_CCCC_DDDD_DDDD, 64'h100, 1'b0);
        tick();
        idle();
        #1;
        chk_out("wrap0", 4'd2, 1'b1, 32'hDDDD_DDDD, 64'h100, 1'b1);
        drive(1'b0, 2'b00, 64'd0, 64'd0, 1'b1);
        tick();
        idle();
        #1;
        chk_out("wrap1", 4'd1, 1'b1, 32'hCCCC_CCCC, 64'h104, 1'b1);
        drive(1'b0, 2'b00, 64'd0, 64'd0, 1'b1);
        tick();
        idle();
        #1;
        chk_out("wrap2", 4'd0, 1'b0, 32'h0, 64'h0, 1'b1);

        // Flush at count 3 with a same-cycle push and pop: both are dropped.
        drive(1'b0, 2'b11, 64'h0000_0002_0000_0001, 64'h200, 1'b0);
        tick();
        drive(1'b0, 2'b01, 64'h0000_0000_0000_0003, 64'h300, 1'b0);
        tick();
        drive(1'b1, 2'b11, 64'hF2F2_F2F2_F1F1_F1F1, 64'h900, 1'b1);
        #1;
        chk("flush_cyc.deq_valid", 64'(deq_valid), 64'd0);
        chk("flush_cyc.enq_ready", 64'(enq_ready), 64'd1);
        chk("flush_cyc.count", 64'(count), 64'd3);
        tick();
        idle();
        #1;
        chk_out("flush_next", 4'd0, 1'b0, 32'h0, 64'h0, 1'b1);
        tick();
        chk("flush_after.count", 64'(count), 64'd0);
        drive(1'b0, 2'b01, 64'h0000_0000_0000_5555, 64'h500, 1'b0);
        tick();
        idle();
        #1;
        chk_out("flush_refill", 4'd1, 1'b1, 32'h0000_5555, 64'h500, 1'b1);

        // Asynchronous reset mid-cycle while holding entries.
        drive(1'b0, 2'b11, 64'h7777_0000_6666_0000, 64'h600, 1'b0);
        tick();
        idle();
        #2;
        reset = 1'b1;
        #1;
        chk_out("async_reset", 4'd0, 1'b0, 32'h0, 64'h0, 1'b1);
        #2;
        reset = 1'b0;
        tick();

        // Random traffic against a queue model of the buffer's contents.
        q.delete();
        holding = 1'b0;
        hv = 2'b00; hi = 64'd0; hp = 64'd0;
        for (int c = 0; c < 10000; c++) begin
            if (!holding) begin
                case ($urandom_range(0, 2))
                    0:       hv = 2'b00;
                    1:       hv = 2'b01;
                    default: hv = 2'b11;
                endcase
                hi = {$urandom, $urandom};
                hp = {$urandom, $urandom};
            end
            f  = ($urandom_range(0, 63) == 0);
            dr = 1'($urandom_range(0, 1));
            drive(f, hv, hi, hp, dr);
            #1;
            exp_rdy = (DEPTH - q.size()) >= 2;
            exp_dv  = (q.size() != 0) && !f;
            chk("rnd.count", 64'(count), 64'(q.size()));
            chk("rnd.count_bound", 64'(count <= 4'(DEPTH)), 64'd1);
            chk("rnd.deq_valid", 64'(deq_valid), 64'(exp_dv));
            chk("rnd.enq_ready", 64'(enq_ready), 64'(exp_rdy));
            chk("rnd.deq_instr", 64'(deq_instr), (q.size() != 0) ? 64'(q[0].instr) : 64'd0);
            chk("rnd.deq_pc", deq_pc, (q.size() != 0) ? q[0].pc : 64'd0);
            if (f) begin
                q.delete();
            end else begin
                if (exp_dv && dr) void'(q.pop_front());
                if (exp_rdy && hv != 2'b00) begin
                    q.push_back('{instr: hi[31:0], pc: hp});
                    if (hv == 2'b11) q.push_back('{instr: hi[63:32], pc: hp + 64'd4});
                end
            end
            holding = (hv != 2'b00) && !exp_rdy && !f;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
